// File: rtl/beep_pkg.sv
// Shared types and constants for the buzzer melody sequencer: FSM states,
// song-entry layout and the base-octave PWM period table.
package beep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_END
  } state_t;

  localparam int PITCH_W = 4;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = PITCH_W + DUR_W;

  localparam logic [DUR_W-1:0] END_MARKER = '0;

  // floor(50e6/f) - 1 for C4..B4 (262, 294, 330, 349, 392, 440, 494 Hz)
  localparam logic [31:0] NOTE_ARR [7] = '{
    32'd190838, 32'd170067, 32'd151514, 32'd143265,
    32'd127550, 32'd113635, 32'd101213
  };

  // Entry 0 sits in the least significant byte.
  localparam logic [2047:0] DEFAULT_SONG = 2048'h00_52_61_61_51_51_11_11;

  function automatic logic is_rest(input logic [PITCH_W-1:0] code);
    return (code == 4'd0) || (code == 4'd15);
  endfunction

  // Codes 8..14 are one octave up: half the period of code-7.
  function automatic logic [31:0] pitch_arr(input logic [PITCH_W-1:0] code);
    logic [2:0]  i;
    logic [31:0] base;
    i = code[3] ? 3'(code - 4'd8) : 3'(code - 4'd1);
    if (is_rest(code)) i = 3'd0;
    base = NOTE_ARR[i];
    return code[3] ? (((base + 32'd1) >> 1) - 32'd1) : base;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous song ROM: one registered 8-bit entry per clock. Addresses past
// the end of the song read back as an end-of-song marker.
module song_rom
  import beep_pkg::*;
#(
  parameter int              SONG_LEN = 32,
  parameter logic [2047:0]   SONG     = DEFAULT_SONG
) (
  input  logic               clk_50mhz,
  input  logic [8:0]         addr,
  output logic [ENTRY_W-1:0] data
);

  localparam logic [8:0] LEN = 9'(SONG_LEN);

  always_ff @(posedge clk_50mhz) begin
    if (addr < LEN) data <= SONG[{addr[7:0], 3'b000} +: ENTRY_W];
    else            data <= {{PITCH_W{1'b0}}, END_MARKER};
  end

endmodule

// File: rtl/beep_melody_sequencer.sv
// Walks the song ROM and drives the PWM generator's enable, period and compare
// inputs for each note, with a silent gap after every note.
module beep_melody_sequencer
  import beep_pkg::*;
#(
  parameter int            BEAT_CYCLES = 12_500_000,
  parameter int            GAP_CYCLES  = 500_000,
  parameter int            SONG_LEN    = 32,
  parameter logic [2047:0] SONG        = DEFAULT_SONG
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [1:0]  vol,
  output logic        pwm_en,
  output logic [31:0] counter_arr,
  output logic [31:0] counter_ccr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  note_idx
);

  localparam logic [8:0]  LEN      = 9'(SONG_LEN);
  localparam logic [35:0] BEAT     = 36'(BEAT_CYCLES);
  localparam logic [35:0] GAP_LAST = 36'(GAP_CYCLES - 1);

  function automatic logic [31:0] duty_ccr(input logic [31:0] arr, input logic [1:0] v);
    return arr >> ({1'b0, v} + 3'd1);
  endfunction

  state_t               state, state_d;
  logic [8:0]           idx, idx_d;
  logic                 pwm_en_d, done_d, load_note, cnt_clr;
  logic [ENTRY_W-1:0]   rom_data;
  logic [PITCH_W-1:0]   rom_pitch;
  logic [DUR_W-1:0]     rom_dur;
  logic [31:0]          note_arr;
  logic [35:0]          cnt, play_last;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .SONG     (SONG)
  ) u_rom (
    .clk_50mhz (clk_50mhz),
    .addr      (idx),
    .data      (rom_data)
  );

  assign rom_pitch = rom_data[ENTRY_W-1:DUR_W];
  assign rom_dur   = rom_data[DUR_W-1:0];
  assign note_arr  = pitch_arr(rom_pitch);
  assign note_idx  = idx[7:0];

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    pwm_en_d  = 1'b0;
    done_d    = 1'b0;
    load_note = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur == END_MARKER || idx == LEN) begin
          state_d = S_END;
        end else begin
          state_d   = S_PLAY;
          load_note = 1'b1;
          cnt_clr   = 1'b1;
          pwm_en_d  = !is_rest(rom_pitch);
        end
      end
      S_PLAY: begin
        if (cnt == play_last) begin
          state_d = S_GAP;
          cnt_clr = 1'b1;
        end else begin
          pwm_en_d = pwm_en;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = S_FETCH;
          idx_d   = idx + 9'd1;
        end
      end
      S_END: begin
        if (loop) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start or note load.
    if (stop) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      pwm_en_d  = 1'b0;
      done_d    = 1'b0;
      load_note = 1'b0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      pwm_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      counter_arr <= '0;
      counter_ccr <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      pwm_en <= pwm_en_d;
      busy   <= (state_d != S_IDLE);
      done   <= done_d;
      // Rests leave the period/compare untouched; pwm_en alone silences them.
      if (load_note && !is_rest(rom_pitch)) begin
        counter_arr <= note_arr;
        counter_ccr <= duty_ccr(note_arr, vol);
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (cnt_clr) cnt <= '0;
    else         cnt <= cnt + 36'd1;
    if (load_note) play_last <= 36'(rom_dur) * BEAT - 36'd1;
  end

endmodule
